// File: rtl/fir_filter_mc.sv
// Multi-channel time-multiplexed FIR: one multiply-accumulate per cycle against a shared
// coefficient RAM, per-channel circular delay lines, rounded and saturated output.
module fir_filter_mc #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 128,
    parameter int CHANNELS = 2,
    parameter int OUT_W    = 32,
    parameter int SHIFT    = 0,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int TAP_W   = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [CH_W-1:0]          s_chan,
    input  logic signed [DATA_W-1:0] xin,
    input  logic                     coef_we,
    input  logic [TAP_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     coef_ready,
    output logic                     y_valid,
    output logic [CH_W-1:0]          y_chan,
    output logic signed [OUT_W-1:0]  y_out,
    output logic                     sat_flag
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + TAP_W;
    localparam logic signed [ACC_W:0] BIAS =
        (SHIFT > 0) ? ((ACC_W+1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    typedef enum logic [1:0] {CLEAR, IDLE, MAC, OUT} state_t;

    state_t state, state_nx;

    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [DATA_W-1:0] dl [CHANNELS][TAPS];
    logic [TAP_W-1:0]         wr_ptr [CHANNELS];

    logic [CH_W-1:0]          clr_ch, chan;
    logic [TAP_W-1:0]         clr_tap, k, rd_idx;
    logic                     out_ph, prod_vld;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    rnd;
    logic signed [OUT_W-1:0]  sat_val;
    logic                     sat_hit;
    logic                     accept, chan_ok, clr_last, mac_last;

    assign accept   = s_valid && (state == IDLE);
    assign chan_ok  = 32'(s_chan) < CHANNELS;
    assign clr_last = (clr_ch == CH_W'(CHANNELS - 1)) && (clr_tap == TAP_W'(TAPS - 1));
    assign mac_last = (k == TAP_W'(TAPS - 1));
    assign rd_idx   = wr_ptr[chan] - k;

    always_ff @(posedge clk) begin
        if (!rst) state <= CLEAR;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        s_ready    = 1'b0;
        coef_ready = 1'b1;
        case (state)
            CLEAR: if (clr_last) state_nx = IDLE;
            IDLE: begin
                s_ready = 1'b1;
                // Out-of-range channels are consumed here without leaving IDLE.
                if (accept && chan_ok) state_nx = MAC;
            end
            MAC: begin
                coef_ready = 1'b0;
                if (mac_last) state_nx = OUT;
            end
            OUT:     if (out_ph) state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    // Products are registered, so OUT spends one cycle draining the last one into acc.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_ch   <= '0;
            clr_tap  <= '0;
            k        <= '0;
            chan     <= '0;
            out_ph   <= 1'b0;
            prod_vld <= 1'b0;
            prod     <= '0;
            acc      <= '0;
            for (int c = 0; c < CHANNELS; c++) wr_ptr[c] <= '0;
            y_valid  <= 1'b0;
            y_chan   <= '0;
            y_out    <= '0;
            sat_flag <= 1'b0;
        end else begin
            y_valid  <= 1'b0;
            prod_vld <= (state == MAC);
            if (prod_vld) acc <= acc + ACC_W'(prod);
            case (state)
                CLEAR: begin
                    clr_tap <= clr_tap + 1'b1;
                    if (clr_tap == TAP_W'(TAPS - 1)) clr_ch <= clr_ch + 1'b1;
                end
                IDLE: begin
                    if (accept && chan_ok) begin
                        chan <= s_chan;
                        k    <= '0;
                        acc  <= '0;
                    end
                end
                MAC: begin
                    prod <= PROD_W'(dl[chan][rd_idx]) * PROD_W'(coef[k]);
                    k    <= k + 1'b1;
                    if (mac_last) wr_ptr[chan] <= wr_ptr[chan] + 1'b1;
                end
                OUT: begin
                    out_ph <= ~out_ph;
                    if (out_ph) begin
                        y_valid  <= 1'b1;
                        y_chan   <= chan;
                        y_out    <= sat_val;
                        sat_flag <= sat_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR)
                dl[clr_ch][clr_tap] <= '0;
            else if (accept && chan_ok)
                dl[s_chan][wr_ptr[s_chan]] <= xin;
        end
    end

    // Coefficient RAM has no reset: it survives rst by design.
    always_ff @(posedge clk) begin
        if (coef_we && coef_ready) coef[coef_addr] <= coef_data;
    end

    assign rnd = ((ACC_W+1)'(acc) + BIAS) >>> SHIFT;

    generate
        if (OUT_W > ACC_W) begin : g_nosat
            assign sat_val = OUT_W'(rnd);
            assign sat_hit = 1'b0;
        end else begin : g_sat
            logic fits;
            assign fits    = (rnd[ACC_W:OUT_W-1] == {(ACC_W-OUT_W+2){rnd[ACC_W]}});
            assign sat_hit = ~fits;
            assign sat_val = fits ? rnd[OUT_W-1:0]
                           : (rnd[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                         : {1'b0, {(OUT_W-1){1'b1}}});
        end
    endgenerate

endmodule

// File: tb/tb_fir_filter_mc.sv
// Directed + randomized bench for fir_filter_mc (TAPS=8, CHANNELS=2); a SHIFT=0 and a
// SHIFT=2 instance share stimulus and are both checked against a sum-of-products model.
module tb_fir_filter_mc;

    localparam int TAPS = 8;
    localparam int CHN  = 2;

    logic              clk, rst, s_valid, coef_we;
    logic [0:0]        s_chan;
    logic signed [15:0] xin, coef_data;
    logic [2:0]        coef_addr;
    logic              s_ready, coef_ready, y_valid, sat_flag;
    logic [0:0]        y_chan;
    logic signed [31:0] y_out;
    logic              s_ready_r, coef_ready_r, y_valid_r, sat_r;
    logic [0:0]        y_chan_r;
    logic signed [31:0] y_out_r;

    int checks = 0;
    int failures = 0;

    int     hist [CHN][TAPS];
    int     h [TAPS];
    longint exp_acc;
    int     exp_ch;

    fir_filter_mc #(.TAPS(TAPS), .CHANNELS(CHN), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan),
        .xin(xin), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_ready(coef_ready), .y_valid(y_valid), .y_chan(y_chan), .y_out(y_out),
        .sat_flag(sat_flag));

    fir_filter_mc #(.TAPS(TAPS), .CHANNELS(CHN), .SHIFT(2)) dut_r (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_r), .s_chan(s_chan),
        .xin(xin), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_ready(coef_ready_r), .y_valid(y_valid_r), .y_chan(y_chan_r), .y_out(y_out_r),
        .sat_flag(sat_r));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic longint model_acc(input int ch);
        longint s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'(h[i]) * longint'(hist[ch][i]);
        return s;
    endfunction

    function automatic longint scale(input longint a, input int sh);
        if (sh > 0) return (a + (longint'(1) <<< (sh - 1))) >>> sh;
        return a;
    endfunction

    function automatic longint clip32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic write_coef(input int idx, input int v);
        coef_we = 1'b1; coef_addr = 3'(idx); coef_data = 16'(v);
        @(posedge clk); #1;
        coef_we = 1'b0;
        h[idx] = v;
    endtask

    task automatic accept_sample(input int ch, input int x);
        int n = 0;
        while (s_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("ready_wait", (n < 100), 1);
        s_valid = 1'b1; s_chan = 1'(ch); xin = 16'(x);
        @(posedge clk); #1;
        s_valid = 1'b0;
        for (int i = TAPS - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
        hist[ch][0] = x;
        exp_acc = model_acc(ch);
        exp_ch  = ch;
    endtask

    task automatic wait_result(input string tag, input int pre);
        int n = pre;
        bit early = 0;
        longint e0, e2;
        do begin
            @(posedge clk); #1; n++;
            if (y_valid !== 1'b1 && s_ready === 1'b1) early = 1;
        end while (y_valid !== 1'b1 && n < 40);
        e0 = clip32(scale(exp_acc, 0));
        e2 = clip32(scale(exp_acc, 2));
        chk({tag, "_lat"}, n, TAPS + 2);
        chk({tag, "_busy"}, early, 0);
        chk({tag, "_rdy"}, s_ready, 1);
        chk({tag, "_ch"}, y_chan, exp_ch);
        chk({tag, "_y"}, y_out, e0);
        chk({tag, "_sat"}, sat_flag, (e0 != scale(exp_acc, 0)));
        chk({tag, "_vr"}, y_valid_r, 1);
        chk({tag, "_yr"}, y_out_r, e2);
        chk({tag, "_satr"}, sat_r, (e2 != scale(exp_acc, 2)));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, y_valid, 0);
        chk({tag, "_hold"}, y_out, e0);
    endtask

    initial begin
        int n, first;
        bit seen;
        logic signed [15:0] r16;

        rst = 1'b0; s_valid = 1'b0; s_chan = '0; xin = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        for (int c = 0; c < CHN; c++) for (int i = 0; i < TAPS; i++) hist[c][i] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sready", s_ready, 0);
        chk("rst_yvalid", y_valid, 0);
        chk("rst_yout", y_out, 0);
        chk("rst_ychan", y_chan, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_cready", coef_ready, 1);
        rst = 1'b1;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("clear_len", n, TAPS * CHN);

        // impulse on ch0
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        accept_sample(0, 1); wait_result("imp0", 0);
        for (int i = 1; i <= TAPS; i++) begin
            accept_sample(0, 0); wait_result($sformatf("imp%0d", i), 0);
        end

        // isolation: ch0 impulse of 100 interleaved with ch1 step
        for (int i = 0; i < TAPS; i++) begin
            accept_sample(0, (i == 0) ? 100 : 0); wait_result($sformatf("iso0_%0d", i), 0);
            accept_sample(1, 1);                  wait_result($sformatf("iso1_%0d", i), 0);
        end

        // randomized coefficients and samples
        for (int i = 0; i < TAPS; i++) begin r16 = 16'($urandom); write_coef(i, r16); end
        for (int i = 0; i < 12; i++) begin
            r16 = 16'($urandom);
            accept_sample(int'($urandom_range(1, 0)), r16);
            wait_result($sformatf("rnd%0d", i), 0);
        end

        // saturation both directions
        for (int i = 0; i < TAPS; i++) write_coef(i, 32767);
        for (int i = 0; i < TAPS; i++) begin
            accept_sample(0, 32767); wait_result($sformatf("satp%0d", i), 0);
        end
        chk("satp_max", y_out, 64'sd2147483647);
        chk("satp_flag", sat_flag, 1);
        for (int i = 0; i < TAPS; i++) begin
            accept_sample(0, -32768); wait_result($sformatf("satn%0d", i), 0);
        end
        chk("satn_min", y_out, -64'sd2147483648);
        chk("satn_flag", sat_flag, 1);

        // rounding on the SHIFT=2 instance
        write_coef(0, 6);
        for (int i = 1; i < TAPS; i++) write_coef(i, 0);
        accept_sample(1, 1);  wait_result("rndp", 0);
        chk("round_pos", y_out_r, 2);
        chk("round_pos_sat", sat_r, 0);
        accept_sample(1, -1); wait_result("rndn", 0);
        chk("round_neg", y_out_r, -1);
        chk("round_neg_sat", sat_r, 0);

        // reset in the middle of MAC: result dropped, delay lines cleared, coefs kept
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        accept_sample(0, 77);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("rstmac_sready", s_ready, 0);
        chk("rstmac_yvalid", y_valid, 0);
        chk("rstmac_yout", y_out, 0);
        chk("rstmac_cready", coef_ready, 1);
        for (int c = 0; c < CHN; c++) for (int i = 0; i < TAPS; i++) hist[c][i] = 0;
        n = 0; first = -1; seen = 0;
        while (n < 40) begin
            @(posedge clk); #1; n++;
            if (y_valid === 1'b1 || y_valid_r === 1'b1) seen = 1;
            if (s_ready === 1'b1 && first < 0) first = n;
        end
        chk("rstmac_noresult", seen, 0);
        chk("rstmac_clear_len", first, TAPS * CHN);
        accept_sample(0, 1); wait_result("rimp0", 0);
        for (int i = 1; i <= TAPS; i++) begin
            accept_sample(0, 0); wait_result($sformatf("rimp%0d", i), 0);
        end

        // coefficient write attempted during MAC is ignored
        accept_sample(0, 1);
        chk("macw_cready", coef_ready, 0);
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd999;
        @(posedge clk); #1;
        coef_we = 1'b0;
        wait_result("macw0", 1);
        for (int i = 1; i <= TAPS; i++) begin
            accept_sample(0, 0); wait_result($sformatf("macw%0d", i), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
